// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order word reads, buffers returned words
// and hands (instr, pc) pairs to decode. A redirect flushes the buffer and drops in-flight words.
module fetch_unit #(
  parameter int                      DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]   RESET_PC   = '0,
  parameter int                      DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_src,
  input  logic [DATA_WIDTH-1:0] pc_target,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         out_q, out_d, cnt_q, cnt_d, drop_q, drop_d;
  logic                  run_q;
  logic [AW-1:0]         tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [AW-1:0]         buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] tag_q, tag_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d;

  logic                  pop, acc, rsp, buf_wr;
  logic [SW-1:0]         occ;
  logic [DATA_WIDTH-1:0] tgt;

  assign tgt         = pc_target & ~DATA_WIDTH'(3);
  assign instr_valid = (cnt_q != '0);
  assign pop         = instr_valid & instr_ready;
  // Reserve a buffer slot for every outstanding request so responses never overflow.
  assign occ            = SW'(out_q) + SW'(cnt_q) - SW'(pop);
  assign imem_req_valid = run_q & ~pc_src & (occ < SW'(DEPTH));
  assign acc            = imem_req_valid & imem_req_ready;
  assign rsp            = imem_rsp_valid;
  assign buf_wr         = rsp & (drop_q == '0) & ~pc_src;
  assign imem_addr      = pc_q;
  assign instr          = buf_instr_q[buf_rd_q];
  assign instr_pc       = buf_pc_q[buf_rd_q];

  always_comb begin
    pc_d        = pc_q;
    out_d       = out_q + CW'(acc) - CW'(rsp);
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    tag_wr_d    = tag_wr_q + AW'(acc);
    tag_rd_d    = tag_rd_q + AW'(rsp);
    tag_d       = tag_q;
    buf_wr_d    = buf_wr_q;
    buf_rd_d    = buf_rd_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    if (acc) tag_d[tag_wr_q] = pc_q;

    if (pc_src) begin
      pc_d     = tgt;
      // Everything still in flight after this cycle is wrong-path.
      drop_d   = out_q - CW'(rsp);
      cnt_d    = '0;
      buf_rd_d = buf_wr_q;
    end else begin
      if (acc) pc_d = pc_q + DATA_WIDTH'(4);
      if (rsp && drop_q != '0) drop_d = drop_q - CW'(1);
      if (buf_wr) begin
        buf_instr_d[buf_wr_q] = imem_rsp_data;
        buf_pc_d[buf_wr_q]    = tag_q[tag_rd_q];
        buf_wr_d              = buf_wr_q + AW'(1);
      end
      if (pop) buf_rd_d = buf_rd_q + AW'(1);
      cnt_d = cnt_q + CW'(buf_wr) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      out_q       <= '0;
      cnt_q       <= '0;
      drop_q      <= '0;
      run_q       <= 1'b0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      buf_wr_q    <= '0;
      buf_rd_q    <= '0;
      tag_q       <= '0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      run_q       <= 1'b1;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      buf_wr_q    <= buf_wr_d;
      buf_rd_q    <= buf_rd_d;
      tag_q       <= tag_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_wr && cnt_q == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable in-order memory model and
// logs of issued addresses and delivered PCs checked against hand-derived values.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, instr_ready;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int lat      = 1;
  int gmark, imark;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] iss[$];
  logic [31:0] got[$];

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .pc_target(pc_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
  endfunction

  // Sample handshakes mid-cycle, advance one clock, then drive the memory response.
  task automatic tick();
    #2;
    if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + lat);
      iss.push_back(imem_addr);
    end
    if (instr_valid && instr_ready) begin
      got.push_back(instr_pc);
      check("instr_word", instr, ~instr_pc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mq_addr[0];
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0; pc_src = 1'b0; pc_target = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_addr", imem_addr, 0);
    rst_n = 1'b1;
    tick();
    // Streaming start, 1-cycle memory
    #1;
    check("a0_req_valid", imem_req_valid, 1);
    check("a0_addr", imem_addr, 32'h0);
    tick();
    #1;
    check("a1_instr_valid", instr_valid, 0);
    check("a1_addr", imem_addr, 32'h4);
    tick();
    instr_ready = 1'b0;
    #1;
    check("a2_instr_valid", instr_valid, 1);
    check("a2_instr_pc", instr_pc, 32'h0);
    check("a2_instr", instr, 32'hFFFF_FFFF);
    check("a2_req_valid", imem_req_valid, 0);
    // Decode backpressure: buffer full, head held
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check("hold_req_valid", imem_req_valid, 0);
      check("hold_instr_pc", instr_pc, 32'h0);
    end
    tick();
    instr_ready = 1'b1;
    imem_req_ready = 1'b0;
    #1;
    check("a7_req_valid", imem_req_valid, 1);
    check("a7_addr", imem_addr, 32'h8);
    // Memory stall holds the address
    tick();
    #1;
    check("a8_addr", imem_addr, 32'h8);
    check("a8_req_valid", imem_req_valid, 1);
    tick();
    #1;
    check("a9_addr", imem_addr, 32'h8);
    check("a9_instr_valid", instr_valid, 0);
    tick();
    imem_req_ready = 1'b1;
    #1;
    check("a10_addr", imem_addr, 32'h8);
    tick();
    #1;
    check("a11_addr", imem_addr, 32'hC);
    check("iss_len", iss.size(), 3);
    check("iss_2", qat(iss, 2), 32'h8);
    imem_req_ready = 1'b0;
    repeat (4) tick();
    #1;
    check("got_len", got.size(), 3);
    check("got_0", qat(got, 0), 32'h0);
    check("got_1", qat(got, 1), 32'h4);
    check("got_2", qat(got, 2), 32'h8);
    check("drained", instr_valid, 0);
    // Redirect with two requests in flight, 2-cycle memory
    lat = 2;
    imem_req_ready = 1'b1;
    #1;
    check("c0_addr", imem_addr, 32'hC);
    tick();
    #1;
    check("c1_addr", imem_addr, 32'h10);
    tick();
    pc_src = 1'b1; pc_target = 32'h103;
    #1;
    check("redir_req_valid", imem_req_valid, 0);
    tick();
    pc_src = 1'b0;
    #1;
    check("c3_addr", imem_addr, 32'h100);
    check("c3_req_valid", imem_req_valid, 1);
    check("c3_instr_valid", instr_valid, 0);
    tick();
    #1;
    check("c4_instr_valid", instr_valid, 0);
    tick();
    #1;
    check("c5_instr_valid", instr_valid, 0);
    tick();
    #1;
    check("c6_instr_valid", instr_valid, 1);
    check("c6_instr_pc", instr_pc, 32'h100);
    check("c6_instr", instr, 32'hFFFF_FEFF);
    check("iss_after_redir", qat(iss, 5), 32'h100);
    // Redirect to the top of the address space, expect wrap to 0
    tick();
    instr_ready = 1'b0;
    pc_src = 1'b1; pc_target = 32'hFFFF_FFFC;
    gmark = got.size();
    imark = iss.size();
    #1;
    check("wrap_redir_req_valid", imem_req_valid, 0);
    tick();
    pc_src = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    repeat (8) tick();
    #1;
    check("got_c6", qat(got, 3), 32'h100);
    check("wrap_iss_0", qat(iss, imark), 32'hFFFF_FFFC);
    check("wrap_iss_1", qat(iss, imark + 1), 32'h0);
    check("wrap_got_0", qat(got, gmark), 32'hFFFF_FFFC);
    check("wrap_got_1", qat(got, gmark + 1), 32'h0);
    // Fill the buffer, then reset mid-stream
    instr_ready = 1'b0;
    repeat (6) tick();
    #1;
    check("full_instr_valid", instr_valid, 1);
    check("full_req_valid", imem_req_valid, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_instr_valid", instr_valid, 0);
    check("mid_rst_req_valid", imem_req_valid, 0);
    check("mid_rst_instr_pc", instr_pc, 0);
    check("mid_rst_addr", imem_addr, 0);
    mq_addr.delete();
    mq_due.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    #1;
    check("restart_req_valid", imem_req_valid, 1);
    check("restart_addr", imem_addr, 32'h0);
    check("restart_instr_valid", instr_valid, 0);
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit. Owns the PC register, issues word reads to instruction memory over a valid/ready request channel, and buffers returned words in a small FIFO.
- Presents (instr, pc) pairs to decode/control with a valid/ready handshake.
- Accepts a redirect (PCsrc plus target) from the execute stage, flushes wrong-path words and restarts fetch at the target.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction words.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction buffer entries. This is also the cap on buffered plus outstanding words. Power of two, 2 or more.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- pc_src  in  1  redirect request (taken branch or jump), single-cycle pulse.
- pc_target  in  DATA_WIDTH  redirect address, sampled when pc_src=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  DATA_WIDTH  fetch address; equals the current PC.
- imem_rsp_valid  in  1  read data valid. Responses are in order; a response never arrives in the same cycle as its own request.
- imem_rsp_data  in  DATA_WIDTH  instruction word.
- instr  out  DATA_WIDTH  buffered instruction to decode.
- instr_pc  out  DATA_WIDTH  PC of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode consumes the head entry.

Behaviour:
- Reset (async, while rst_n=0):
  - pc=RESET_PC; buffer empty; outstanding=0; drop=0.
  - imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
  - First request is raised in the first cycle after rst_n rises.
- Counters:
  - outstanding: requests accepted but not yet responded to, range 0..DEPTH.
  - count: buffer occupancy, range 0..DEPTH.
  - pop = instr_valid & instr_ready.
- Issue: imem_req_valid = (outstanding + count - pop < DEPTH) & ~pc_src.
  - On accept (valid & ready): pc <= pc+4, wrapping modulo 2^DATA_WIDTH. Record the PC of each accepted request in an in-order tag queue (DEPTH entries).
  - imem_addr stays stable while imem_req_valid=1 and ready=0.
- Response: pops the tag queue.
  - If drop>0: discard the word and decrement drop.
  - Otherwise write (word, tag PC) into the buffer. Space is guaranteed by the issue rule, so overflow is impossible. Flag an assertion if the buffer is full.
- Output: instr_valid = count>0. instr/instr_pc come from the buffer head. There is no bypass, so a word written in cycle N is visible in cycle N+1.
- Latency: with a zero-wait memory (ready=1, response 1 cycle after accept), the first instr_valid occurs 2 cycles after the first accept. Steady state is 1 instruction per cycle while instr_ready=1.
- Redirect (pc_src=1):
  - Next cycle: pc=pc_target with bits[1:0] forced to 00. Buffer emptied, so instr_valid=0 next cycle.
  - drop = outstanding-after-this-cycle. This counts responses arriving this same cycle as already consumed, and keeps the tag queue in step.
  - imem_req_valid is 0 during the redirect cycle.
  - A pop in the same cycle is allowed; the flush wins.
- Simultaneous response and pop: both take effect; count is unchanged.
- Backpressure: instr_ready=0 holds the head entry. Issue stops once outstanding+count=DEPTH.
- Redirect while drop>0: drop is set to the new outstanding total, never cumulative double-counting.
- rst_n asserted mid-operation: immediate return to reset state. In-flight responses after reset release are not legal stimulus.

Test Plan:
- Reset, ready=1, 1-cycle memory, instr_ready=1 -> requests at addresses 0x0, 0x4, 0x8… on consecutive cycles. instr_valid first high 2 cycles after the first accept, with instr_pc=0x0, then one per cycle.
- instr_ready=0 for 5 cycles after the first instr_valid -> buffer holds 2 entries (pc 0x0, 0x4), no third request issued, head stable. On release, 0x0, 0x4, 0x8 are delivered in order with no loss or duplicate.
- imem_req_ready=0 for 3 cycles at pc=0x8 -> imem_addr held at 0x8 with valid high; after ready=1, the next address is 0xC.
- pc_src=1, pc_target=0x103, while 2 requests are outstanding -> those 2 responses are discarded. Next request address is 0x100, and the next instr_valid carries instr_pc=0x100.
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC, then 0x0000_0000 (wrap).
- rst_n pulled low mid-stream with the buffer full -> instr_valid=0 and imem_req_valid=0 immediately. After release, fetch restarts at RESET_PC.
